btn_step_counter: RTL
=====================

Name: btn_step_counter

Overview:
Parametrised multi-channel push-button step counter. Each channel synchronises a raw button, applies press and release lockout windows measured in ticks, and steps a modulo-MODULUS counter up or down. Optional auto-repeat steps the counter while a button is held. A registered all-equal flag is produced for the pixel-colour logic that feeds the OLED renderer, which lights the match indicator when all channels agree.

Parameters:
N_CH, 3, number of button channels (>=1)
CNT_W, 3, counter width per channel; must satisfy 2^CNT_W >= MODULUS
MODULUS, 6, count range 0..MODULUS-1 (>=2)
TICK_DIV, 100000, CLK cycles per lockout tick (1 kHz at 100 MHz; >=2)
LOCKOUT_TICKS, 200, press and release lockout length in ticks (>=1)
REPEAT_TICKS, 0, auto-repeat delay and period in ticks while held; 0 disables auto-repeat

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
btn  in  N_CH  raw asynchronous buttons, active-high
dir  in  N_CH  per-channel direction: 0 = up, 1 = down; sampled when a step occurs
clr_all  in  1  synchronous clear of all counts (already synchronous to CLK)
count  out  N_CH*CNT_W  counts; channel i occupies bits [i*CNT_W +: CNT_W]
step_pulse  out  N_CH  one-cycle pulse on each step of the channel
held  out  N_CH  1 while the channel FSM is in HELD
all_equal  out  1  registered: 1 when every channel count is equal
match_val  out  CNT_W  registered copy of channel 0 count, aligned with all_equal

Behaviour:
- Reset (RESETn=0, asynchronous): count=0, step_pulse=0, held=0, all_equal=1, match_val=0, tick divider=0, synchronisers=0, all FSMs in IDLE, timers=0.
- Tick: a free-running divider counts 0..TICK_DIV-1. tick is a one-cycle strobe when the divider wraps. It is shared by all channels.
- Synchroniser: 2-FF per channel. btn sampled high at edge k makes btn_s=1 after edge k+1.
- Per-channel FSM:
  - IDLE: on btn_s=1, step the counter and pulse step_pulse (count and pulse visible after edge k+2). Load timer=LOCKOUT_TICKS and go to LOCK_P.
  - LOCK_P: ignore btn. Decrement timer on each tick. When timer reaches 0, go to HELD if btn_s=1, else go to LOCK_R with timer reloaded.
  - HELD: held=1. On btn_s=0, load timer=LOCKOUT_TICKS and go to LOCK_R. If REPEAT_TICKS>0, a repeat timer counts ticks from entry to HELD. When it reaches REPEAT_TICKS, step the counter, pulse step_pulse and reload the repeat timer. Release takes priority over a same-cycle repeat.
  - LOCK_R: ignore btn. Decrement timer on each tick. At 0, go to IDLE.
  - Lockout duration is between LOCKOUT_TICKS-1 and LOCKOUT_TICKS tick periods because the first tick may be partial.
- Step arithmetic:
  - up: count==MODULUS-1 wraps to 0, otherwise count+1.
  - down: count==0 wraps to MODULUS-1, otherwise count-1.
- clr_all: sets all counts to 0 at the next edge and wins over a same-cycle step. step_pulse still fires. FSM state and timers are unaffected.
- Channels step independently. Simultaneous presses on several channels all step in the same cycle.
- all_equal and match_val are registered one cycle after the count change (edge k+3 for a press sampled at k).
- A RESETn assertion mid-lockout or mid-hold returns the channel to IDLE. After reset is released, a still-held button produces a new step (after synchroniser latency).
- Count values >= MODULUS are unreachable.

Decomposition:
- Shared package: channel FSM state typedef (IDLE, LOCK_P, HELD, LOCK_R), default TICK_DIV, default LOCKOUT_TICKS, colour constants used downstream.
- Sub-module btn_channel: synchroniser, FSM, lockout/repeat timers and counter for one channel. Instantiated N_CH times by generate.
- Tick divider and the all_equal comparator live in the top level.

Test Plan (TICK_DIV=4, LOCKOUT_TICKS=3, MODULUS=6, N_CH=3 unless stated):
- Reset: hold RESETn=0 with btn=3'b111 → count=0, all_equal=1, no step_pulse. Release → each channel steps once to 1 after 2 edges.
- Wrap: six clean up-presses on ch0 (each held 20 cycles, gaps of 20 cycles) → ch0 count goes 1,2,3,4,5,0. Exactly six step_pulses.
- Lockout: ch1 press, with btn bouncing 0/1 every cycle for 8 cycles, then steady 1 → exactly one step, count=1. Bounce on release → no extra step.
- Down and clear: dir[2]=1 on a press from 0 → count=5. Press on ch0 with clr_all=1 in the same step cycle → ch0=0 and step_pulse[0]=1.
- Auto-repeat: REPEAT_TICKS=2, hold ch0 for 40 cycles → first step, then a step every 8 cycles while HELD. held=1 during hold, 0 after release.
- Match: drive all three channels to 4 → all_equal=1 and match_val=4 one cycle after the last count update. One more ch2 step → all_equal=0.

Source files
------------

// File: rtl/btn_step_counter_pkg.sv
// Shared types and constants for the push-button step counter and the
// OLED colour logic that consumes its match flag.
package btn_step_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK_P,
    ST_HELD,
    ST_LOCK_R
  } ch_state_e;

  localparam int unsigned DEF_TICK_DIV      = 100000;
  localparam int unsigned DEF_LOCKOUT_TICKS = 200;

  // RGB565 colours for the match indicator on the OLED renderer
  localparam logic [15:0] COLOR_MATCH    = 16'h07E0;
  localparam logic [15:0] COLOR_NO_MATCH = 16'hF800;
  localparam logic [15:0] COLOR_BG       = 16'h0000;

  function automatic int unsigned step_value(input int unsigned cur,
                                             input logic        down,
                                             input int unsigned modulus);
    if (down) begin
      return (cur == 0) ? modulus - 1 : cur - 1;
    end
    return (cur == modulus - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/btn_step_counter_channel.sv
// One button channel: 2-FF synchroniser, press/release lockout FSM with
// optional auto-repeat, and the modulo step counter.
module btn_channel
  import btn_step_counter_pkg::*;
#(
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned MODULUS       = 6,
  parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
  parameter int unsigned REPEAT_TICKS  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             btn,
  input  logic             dir,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step_pulse,
  output logic             held
);

  localparam int unsigned TMR_W = $clog2(LOCKOUT_TICKS + 1);
  localparam int unsigned REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_TICKS);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

  ch_state_e        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_pulse_q, step_pulse_d;
  logic             held_q, held_d;
  logic             btn_s;
  logic             step;

  assign btn_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], btn};
    state_d = state_q;
    timer_d = timer_q;
    rep_d   = rep_q;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          step    = 1'b1;
          timer_d = TMR_LOAD;
          state_d = ST_LOCK_P;
        end
      end
      ST_LOCK_P: begin
        // Transition happens on the tick that would take the timer to zero
        if (tick) begin
          if (timer_q == TMR_ONE) begin
            rep_d = '0;
            if (btn_s) begin
              state_d = ST_HELD;
            end else begin
              state_d = ST_LOCK_R;
              timer_d = TMR_LOAD;
            end
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_LOCK_R;
          timer_d = TMR_LOAD;
        end else if ((REPEAT_TICKS != 0) && tick) begin
          if (rep_q == REP_LAST) begin
            step  = 1'b1;
            rep_d = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
      end
      ST_LOCK_R: begin
        if (tick) begin
          if (timer_q == TMR_ONE) begin
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (step) begin
      count_d = CNT_W'(step_value(int'(count_q), dir, MODULUS));
    end
    step_pulse_d = step;
    held_d       = (state_d == ST_HELD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      timer_q      <= '0;
      rep_q        <= '0;
      count_q      <= '0;
      step_pulse_q <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      timer_q      <= timer_d;
      rep_q        <= rep_d;
      count_q      <= count_d;
      step_pulse_q <= step_pulse_d;
      held_q       <= held_d;
    end
  end

  assign count      = count_q;
  assign step_pulse = step_pulse_q;
  assign held       = held_q;

endmodule

// File: rtl/btn_step_counter.sv
// Multi-channel push-button step counter: shared lockout tick divider,
// N_CH button channels and a registered all-channels-equal flag.
module btn_step_counter
  import btn_step_counter_pkg::*;
#(
  parameter int unsigned N_CH          = 3,
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned MODULUS       = 6,
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
  parameter int unsigned LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
  parameter int unsigned REPEAT_TICKS  = 0
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [N_CH-1:0]        btn,
  input  logic [N_CH-1:0]        dir,
  input  logic                   clr_all,
  output logic [N_CH*CNT_W-1:0]  count,
  output logic [N_CH-1:0]        step_pulse,
  output logic [N_CH-1:0]        held,
  output logic                   all_equal,
  output logic [CNT_W-1:0]       match_val
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             all_equal_q, all_equal_d;
  logic [CNT_W-1:0] match_val_q, match_val_d;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .CNT_W         (CNT_W),
      .MODULUS       (MODULUS),
      .LOCKOUT_TICKS (LOCKOUT_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_channel (
      .clk        (CLK),
      .rst_n      (RESETn),
      .tick       (tick),
      .btn        (btn[g]),
      .dir        (dir[g]),
      .clr        (clr_all),
      .count      (count[g*CNT_W +: CNT_W]),
      .step_pulse (step_pulse[g]),
      .held       (held[g])
    );
  end

  always_comb begin
    all_equal_d = 1'b1;
    for (int unsigned i = 1; i < N_CH; i++) begin
      if (count[i*CNT_W +: CNT_W] != count[CNT_W-1:0]) begin
        all_equal_d = 1'b0;
      end
    end
    match_val_d = count[CNT_W-1:0];
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      div_q       <= '0;
      all_equal_q <= 1'b1;
      match_val_q <= '0;
    end else begin
      div_q       <= div_d;
      all_equal_q <= all_equal_d;
      match_val_q <= match_val_d;
    end
  end

  assign all_equal = all_equal_q;
  assign match_val = match_val_q;

endmodule
